// File: rtl/gmii_axis_frame_rx.sv
// GMII/MII frame receiver feeding the MAC RX FIFO as a byte-wide AXI4-Stream.
// It strips the preamble and SFD, checks the CRC-32 over payload plus FCS, and
// holds the last five bytes back so the four FCS bytes are never emitted.
// The stream has no backpressure, so the downstream FIFO must always accept.
// Nibble order and the clk_enable_i / mii_select_i handling match the GMII
// transmitter.
// Optional build macro GMII_RX_PTP_TS_EN: when defined, ptp_ts_i is captured
// at SFD acceptance and driven on m_axis_tuser_o[USER_WIDTH-1:1] for the whole
// frame. When it is not defined, those tuser bits are tied to 0.

module gmii_axis_frame_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int PTP_TS_WIDTH = 96,
    parameter int USER_WIDTH   = PTP_TS_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   gmii_rxd_i,
    input  logic                    gmii_rx_dv_i,
    input  logic                    gmii_rx_er_i,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
    output logic                    m_axis_tvalid_o,
    output logic                    m_axis_tlast_o,
    output logic [USER_WIDTH-1:0]   m_axis_tuser_o,
    input  logic [PTP_TS_WIDTH-1:0] ptp_ts_i,
    input  logic                    clk_enable_i,
    input  logic                    mii_select_i,
    output logic                    start_packet_o,
    output logic                    error_bad_frame_o,
    output logic                    error_bad_fcs_o
);

    if (DATA_WIDTH != 8) begin : g_width_check
        $error("gmii_axis_frame_rx: DATA_WIDTH must be 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Reflected CRC-32 (poly 0x04C11DB7), one byte at a time, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    logic [7:0]  rxd_q;
    logic        dv_q;
    logic        er_q;
    logic        mii_phase_q;
    logic [3:0]  mii_lo_q;
    logic        mii_er_q;

    state_t      state_q;
    logic [31:0] crc_q;
    logic [7:0]  dl_q [5];
    logic [2:0]  cnt_q;
    logic        er_seen_q;

    logic [7:0]  tdata_q;
    logic        tvalid_q;
    logic        tlast_q;
    logic        tuser0_q;
    logic        start_q;
    logic        bad_frame_q;
    logic        bad_fcs_q;

    logic        ev;
    logic        ev_dv;
    logic        ev_er;
    logic        ev_odd;
    logic [7:0]  ev_byte;
    logic        sfd_accept;
    logic        fcs_bad;
    logic        end_bad;

    // Register the line inputs on every enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_q <= '0;
            dv_q  <= 1'b0;
            er_q  <= 1'b0;
        end else if (clk_enable_i) begin
            rxd_q <= gmii_rxd_i;
            dv_q  <= gmii_rx_dv_i;
            er_q  <= gmii_rx_er_i;
        end
    end

    // MII: the low nibble is held until its high nibble arrives, and the
    // phase restarts whenever dv is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            mii_phase_q <= 1'b0;
            mii_lo_q    <= '0;
            mii_er_q    <= 1'b0;
        end else if (clk_enable_i) begin
            if (!mii_select_i || !dv_q) begin
                mii_phase_q <= 1'b0;
            end else begin
                if (!mii_phase_q) begin
                    mii_lo_q <= rxd_q[3:0];
                    mii_er_q <= er_q;
                end
                mii_phase_q <= ~mii_phase_q;
            end
        end
    end

    // Byte event: one per cycle in GMII, one per nibble pair in MII. A dv-low
    // cycle is always an event so the FSM can see the frame end.
    always_comb begin
        ev      = 1'b0;
        ev_dv   = dv_q;
        ev_er   = er_q;
        ev_odd  = 1'b0;
        ev_byte = rxd_q;
        if (!mii_select_i) begin
            ev = 1'b1;
        end else if (!dv_q) begin
            ev     = 1'b1;
            ev_odd = mii_phase_q;
        end else if (mii_phase_q) begin
            ev      = 1'b1;
            ev_byte = {rxd_q[3:0], mii_lo_q};
            ev_er   = er_q | mii_er_q;
        end
    end

    assign sfd_accept = (state_q == ST_IDLE) && ev && ev_dv && !ev_er && (ev_byte == 8'hD5);
    assign fcs_bad    = (crc_q != CRC_RESIDUE);
    // A frame that ends on half a byte counts as an errored frame.
    assign end_bad    = er_seen_q | ev_odd;

    // Frame FSM with CRC, 5-byte delay line and registered stream outputs.
    //   IDLE    | hunting for preamble bytes (0x55) and the SFD (0xD5)
    //   PAYLOAD | in frame; bytes go through the CRC and the delay line
    //   DROP    | bad preamble; discard input until dv falls
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            crc_q       <= 32'hFFFFFFFF;
            for (int i = 0; i < 5; i++) dl_q[i] <= '0;
            cnt_q       <= '0;
            er_seen_q   <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser0_q    <= 1'b0;
            start_q     <= 1'b0;
            bad_frame_q <= 1'b0;
            bad_fcs_q   <= 1'b0;
        end else if (clk_enable_i) begin
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            start_q     <= 1'b0;
            bad_frame_q <= 1'b0;
            bad_fcs_q   <= 1'b0;
            if (ev) begin
                case (state_q)
                    ST_IDLE: begin
                        if (ev_dv) begin
                            if (ev_er || (ev_byte != 8'h55 && ev_byte != 8'hD5)) begin
                                state_q <= ST_DROP;
                            end else if (ev_byte == 8'hD5) begin
                                state_q   <= ST_PAYLOAD;
                                start_q   <= 1'b1;
                                crc_q     <= 32'hFFFFFFFF;
                                cnt_q     <= '0;
                                er_seen_q <= 1'b0;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (ev_dv) begin
                            crc_q <= crc_next(crc_q, ev_byte);
                            for (int i = 4; i > 0; i--) dl_q[i] <= dl_q[i-1];
                            dl_q[0] <= ev_byte;
                            if (ev_er) er_seen_q <= 1'b1;
                            if (cnt_q == 3'd5) begin
                                tdata_q  <= dl_q[4];
                                tvalid_q <= 1'b1;
                                tuser0_q <= 1'b0;
                            end else begin
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                            if (cnt_q == 3'd5) begin
                                tdata_q     <= dl_q[4];
                                tvalid_q    <= 1'b1;
                                tlast_q     <= 1'b1;
                                tuser0_q    <= fcs_bad | end_bad;
                                bad_fcs_q   <= fcs_bad;
                                bad_frame_q <= end_bad;
                            end else begin
                                bad_frame_q <= 1'b1;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (!ev_dv) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef GMII_RX_PTP_TS_EN
    logic [PTP_TS_WIDTH-1:0] ts_q;

    // Capture the PTP time on the cycle the SFD is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else if (clk_enable_i && sfd_accept) begin
            ts_q <= ptp_ts_i;
        end
    end

    assign m_axis_tuser_o = {ts_q, tuser0_q};
`else
    logic unused_ptp_ts;
    assign unused_ptp_ts  = ^{ptp_ts_i, sfd_accept};
    assign m_axis_tuser_o = {{(USER_WIDTH-1){1'b0}}, tuser0_q};
`endif

    // Each registered beat or pulse is held through disabled cycles and is
    // presented in exactly one enabled cycle.
    assign m_axis_tdata_o    = tdata_q;
    assign m_axis_tlast_o    = tlast_q;
    assign m_axis_tvalid_o   = tvalid_q & clk_enable_i;
    assign start_packet_o    = start_q & clk_enable_i;
    assign error_bad_frame_o = bad_frame_q & clk_enable_i;
    assign error_bad_fcs_o   = bad_fcs_q & clk_enable_i;

endmodule

// File: tb/tb_gmii_axis_frame_rx.sv
// Self-checking bench for gmii_axis_frame_rx: directed frames with expected
// beats queued on the scoreboard as they are driven.
module tb_gmii_axis_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  gmii_rxd = '0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic [96:0] m_axis_tuser;
    logic [95:0] ptp_ts = '0;
    logic        clk_enable = 1'b1;
    logic        mii_select = 1'b0;
    logic        start_packet;
    logic        error_bad_frame;
    logic        error_bad_fcs;

    always #5 clk = ~clk;

    gmii_axis_frame_rx dut (
        .clk               (clk),
        .rst               (rst),
        .gmii_rxd_i        (gmii_rxd),
        .gmii_rx_dv_i      (gmii_rx_dv),
        .gmii_rx_er_i      (gmii_rx_er),
        .m_axis_tdata_o    (m_axis_tdata),
        .m_axis_tvalid_o   (m_axis_tvalid),
        .m_axis_tlast_o    (m_axis_tlast),
        .m_axis_tuser_o    (m_axis_tuser),
        .ptp_ts_i          (ptp_ts),
        .clk_enable_i      (clk_enable),
        .mii_select_i      (mii_select),
        .start_packet_o    (start_packet),
        .error_bad_frame_o (error_bad_frame),
        .error_bad_fcs_o   (error_bad_fcs)
    );

    typedef struct {
        logic [7:0]  d;
        logic        last;
        logic        bad;
        logic [95:0] ts;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_put_cyc = 0;
    int          lat_t0 = 0;
    int          lat_obs = 0;
    bit          lat_arm = 0;
    bit          sb_off = 0;
    bit          mii = 0;
    bit          tgl = 0;
    int          n_beats = 0, n_last = 0, n_start = 0, n_fcs = 0, n_frm = 0;
    logic [95:0] exp_ts = '0;
    logic [7:0]  pl [0:127];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC-32 used to build the FCS that is sent on the line.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Monitor: compare every beat against the scoreboard and count the pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid) begin
                beat_t e;
                chk("tvalid_with_enable", clk_enable, 1);
                n_beats++;
                if (m_axis_tlast) n_last++;
                if (lat_arm) begin
                    lat_obs = cyc;
                    lat_arm = 0;
                end
                if (!sb_off) begin
                    chk("sb_empty_at_beat", sb.size() == 0, 0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("tdata", m_axis_tdata, e.d);
                        chk("tlast", m_axis_tlast, e.last);
                        chk("tuser_bad", m_axis_tuser[0], e.bad);
                        chk("tuser_ts", m_axis_tuser[96:1], e.ts);
                    end
                end
            end
            if (start_packet) n_start++;
            if (error_bad_fcs) begin
                n_fcs++;
                chk("fcs_pulse_on_tlast", m_axis_tvalid & m_axis_tlast, 1);
            end
            if (error_bad_frame) n_frm++;
        end
    end

    task automatic put(input logic dv, input logic er, input logic [7:0] d);
        @(posedge clk); #1;
        gmii_rx_dv   = dv;
        gmii_rx_er   = er;
        gmii_rxd     = d;
        clk_enable   = 1'b1;
        last_put_cyc = cyc;
        if (tgl) begin
            @(posedge clk); #1;
            clk_enable = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic er);
        if (mii) begin
            put(1'b1, er, {4'h0, b[3:0]});
            put(1'b1, er, {4'h0, b[7:4]});
        end else begin
            put(1'b1, er, b);
        end
    endtask

    task automatic set_ts(input logic [95:0] v);
        ptp_ts = v;
`ifdef GMII_RX_PTP_TS_EN
        exp_ts = v;
`else
        exp_ts = '0;
`endif
    endtask

    task automatic fill(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic send_frame(input int len, input int er_idx, input bit flip,
                              input bit bad_pre, input bit expect_beats);
        logic [31:0] c;
        logic [31:0] f;
        beat_t       e;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) send_byte((bad_pre && i == 3) ? 8'h57 : 8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (expect_beats) begin
                e.d    = pl[i];
                e.last = (i == len - 1);
                e.bad  = (i == len - 1) && (flip || er_idx >= 0);
                e.ts   = exp_ts;
                sb.push_back(e);
            end
            if (i == 2) ptp_ts = ~ptp_ts;
            send_byte(pl[i], i == er_idx);
            if (i == 0) lat_t0 = last_put_cyc;
            c = crc_upd(c, pl[i]);
        end
        f = ~c;
        if (flip) f[7:0] = f[7:0] ^ 8'hFF;
        for (int k = 0; k < 4; k++) send_byte(f[8*k +: 8], 1'b0);
        put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic end_test(input string tag, input int beats, input int starts,
                            input int fcs, input int frm);
        repeat (30) put(1'b0, 1'b0, 8'h00);
        chk({tag, "_beats"}, n_beats, beats);
        chk({tag, "_sb_drained"}, sb.size(), 0);
        chk({tag, "_start"}, n_start, starts);
        chk({tag, "_bad_fcs"}, n_fcs, fcs);
        chk({tag, "_bad_frame"}, n_frm, frm);
        sb.delete();
        n_beats = 0; n_last = 0; n_start = 0; n_fcs = 0; n_frm = 0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) put(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_start", start_packet, 0);
        chk("rst_bad_frame", error_bad_frame, 0);
        chk("rst_bad_fcs", error_bad_fcs, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) put(1'b0, 1'b0, 8'h00);

        // Good GMII frame and first-beat latency.
        set_ts(96'h0);
        fill(60);
        lat_arm = 1;
        send_frame(60, -1, 1'b0, 1'b0, 1'b1);
        end_test("good", 60, 1, 0, 0);
        chk("latency", lat_obs - lat_t0, 7);

        // Corrupted FCS byte.
        fill(60);
        send_frame(60, -1, 1'b1, 1'b0, 1'b1);
        end_test("fcs", 60, 1, 1, 0);

        // rx_er on payload byte 20.
        fill(60);
        send_frame(60, 19, 1'b0, 1'b0, 1'b1);
        end_test("rxer", 60, 1, 0, 1);

        // Bad preamble byte: whole frame dropped.
        fill(60);
        send_frame(60, -1, 1'b0, 1'b1, 1'b0);
        end_test("drop", 0, 0, 0, 0);

        // Runt (SFD + 3 bytes) then a good 64-byte frame after one idle cycle.
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h10 + i), 1'b0);
        put(1'b0, 1'b0, 8'h00);
        fill(64);
        send_frame(64, -1, 1'b0, 1'b0, 1'b1);
        end_test("b2b", 64, 2, 0, 1);

        // MII with clk_enable toggling every cycle.
        mii = 1; tgl = 1; mii_select = 1'b1;
        fill(46);
        send_frame(46, -1, 1'b0, 1'b0, 1'b1);
        end_test("mii", 46, 1, 0, 0);
        tgl = 0; mii = 0; mii_select = 1'b0;
        put(1'b0, 1'b0, 8'h00);

        // Timestamp captured at SFD and held for the frame.
        set_ts(96'h1234);
        fill(30);
        send_frame(30, -1, 1'b0, 1'b0, 1'b1);
        end_test("ptp", 30, 1, 0, 0);

        // Reset mid-payload: no tlast, then a clean frame.
        sb_off = 1;
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'(8'h40 + i), 1'b0);
        rst = 1'b1;
        put(1'b1, 1'b0, 8'hAA);
        put(1'b1, 1'b0, 8'hAB);
        rst = 1'b0;
        repeat (30) put(1'b0, 1'b0, 8'h00);
        chk("rst_mid_no_tlast", n_last, 0);
        chk("rst_mid_no_bad_frame", n_frm, 0);
        chk("rst_mid_no_bad_fcs", n_fcs, 0);
        n_beats = 0; n_last = 0; n_start = 0; n_fcs = 0; n_frm = 0;
        sb_off = 0;
        set_ts(96'h5678);
        fill(40);
        send_frame(40, -1, 1'b0, 1'b0, 1'b1);
        end_test("post_rst", 40, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmii_axis_frame_rx.md
Name: gmii_axis_frame_rx

Overview:
GMII/MII frame receiver: strips preamble/SFD and FCS from the incoming line, checks the CRC-32, and emits the payload as AXI4-Stream, one byte per beat.
- Sits between the PHY-side GMII input registers and the MAC RX FIFO.
- Mirror of the team's GMII transmitter: same nibble ordering and clk_enable/mii_select conventions.
- Has no backpressure; the downstream FIFO must always accept.

Parameters:
DATA_WIDTH, 8, byte width; any other value is an elaboration error.
PTP_TS_WIDTH, 96, width of the PTP timestamp input.
USER_WIDTH, PTP_TS_WIDTH+1, m_axis_tuser width; bit 0 = bad frame, upper bits = timestamp.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
gmii_rxd  in  8  receive data; MII mode uses [3:0] only
gmii_rx_dv  in  1  data valid
gmii_rx_er  in  1  receive error
m_axis_tdata  out  8  payload byte
m_axis_tvalid  out  1  beat valid; single-cycle per byte
m_axis_tlast  out  1  last payload byte
m_axis_tuser  out  USER_WIDTH  [0] bad frame on tlast beat; [USER_WIDTH-1:1] timestamp
ptp_ts  in  PTP_TS_WIDTH  free-running PTP time
clk_enable  in  1  qualifies every cycle; 0 = hold all state, m_axis_tvalid forced 0
mii_select  in  1  1 = MII nibble mode, 0 = GMII byte mode
start_packet  out  1  1-cycle pulse on SFD accept
error_bad_frame  out  1  1-cycle pulse: frame ended with rx_er seen, or was a runt
error_bad_fcs  out  1  1-cycle pulse: CRC mismatch

Behaviour:
- Reset: all outputs 0, FSM in IDLE, CRC register 32'hFFFFFFFF, delay line cleared. A reset mid-frame discards the frame; no tlast is emitted.
- Input stage: gmii_rxd, gmii_rx_dv and gmii_rx_er are registered on each enabled cycle.
- MII nibble assembly:
  - The first nibble after a dv rise is the low nibble. A byte completes every 2nd enabled cycle.
  - The phase resets when dv is low.
  - The rx_er value used for a byte is the OR over both of its nibbles.
- Delay line: 5 bytes deep, holding back the 4 FCS bytes so they are never emitted.
- Latency: a payload byte appears on m_axis 7 enabled byte-times after it is presented on gmii_rxd (GMII). MII mode uses the same latency counted in assembled-byte times.
- CRC-32: poly 0x04C11DB7, reflected Galois, init FFFFFFFF. It covers all bytes after SFD, including FCS. The FCS is good iff the register equals 32'hDEBB20E3 after the last FCS byte.
- FSM states:
  - IDLE: wait for dv=1. Byte 0x55 stays in IDLE (preamble). Byte 0xD5 goes to PAYLOAD, pulses start_packet, latches ptp_ts, resets CRC. Any other byte, or rx_er, goes to DROP.
  - PAYLOAD: shift bytes through the CRC and the delay line. Once the delay line is full (5 bytes), each new byte pushes the oldest one out as a beat: tvalid=1, tlast=0. When registered dv falls, the oldest delay-line byte is the last payload byte.
    - If at least 5 bytes were received after SFD: emit that byte with tlast=1. tuser[0] = fcs_bad | er_seen. Pulse error_bad_fcs/error_bad_frame on the same cycle as the tlast beat. Go to IDLE.
    - If fewer than 5 bytes were received (runt): emit no beats, pulse error_bad_frame, go to IDLE.
  - DROP: ignore input until dv=0, then go to IDLE. No beats, no error pulses.
- er_seen: sticky flag, set by rx_er on any dv=1 byte in PAYLOAD; cleared on SFD.
- dv falling in the middle of an MII byte (odd nibble): treated as er_seen=1 and the frame ends normally.
- Back-to-back frames with 0 IFG: dv re-rising on the cycle after the fall starts a new frame correctly.
- tuser[USER_WIDTH-1:1]: constant for the whole frame, from the SFD capture.
- A clk_enable=0 cycle freezes the FSM, counters and delay line.

Optional Feature:
GMII_RX_PTP_TS_EN
- Defined: ptp_ts is sampled on the enabled cycle in which the SFD is accepted, and presented on m_axis_tuser[USER_WIDTH-1:1] for every beat of that frame.
- Undefined: the capture register is not built, those tuser bits are tied 0, and ptp_ts is ignored.
- tuser[0] behaviour is identical in both cases.

Test Plan:
- GMII, 7x55+D5 preamble, 60-byte payload + correct FCS -> 60 beats, tlast on byte 60, tuser[0]=0, one start_packet, no error pulses, first beat 7 cycles after first payload byte.
- Same frame with one FCS byte flipped -> 60 beats, tuser[0]=1 on tlast, error_bad_fcs pulse coincident with the tlast beat.
- rx_er asserted on payload byte 20 -> tuser[0]=1, error_bad_frame pulse; a frame with preamble byte 0x57 -> DROP, zero beats.
- Runt: SFD + 3 bytes -> zero beats, error_bad_frame pulse; then immediate good 64-byte frame with 0 IFG -> received intact.
- MII mode with clk_enable toggling 1/0 every cycle, 46-byte payload -> same byte stream as GMII, tvalid never high while clk_enable=0.
- GMII_RX_PTP_TS_EN defined, ptp_ts=0x1234 at SFD -> tuser[96:1]=0x1234 on all beats; rst pulsed mid-payload -> no tlast, next frame clean.
